// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_N = 32;

  // Radix-2: one quotient/product bit is resolved per iteration.
  localparam int MDU_ITERS_PER_BIT = 1;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on unsigned magnitudes.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int n = MDU_N
) (
  input  logic         div_mode,
  input  logic [n-1:0] acc_hi,
  input  logic [n-1:0] acc_lo,
  input  logic [n-1:0] operand,
  output logic [n-1:0] next_hi,
  output logic [n-1:0] next_lo
);

  logic [n:0] sum;
  logic [n:0] shifted;
  logic [n:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(n+1){1'b0}});
    shifted = {acc_hi, acc_lo[n-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = sum[n:1];
    next_lo = {sum[0], acc_lo[n-1:1]};
    if (div_mode) begin
      // Partial remainder stays below the divisor, so n bits always suffice.
      next_hi = diff[n] ? shifted[n-1:0] : diff[n-1:0];
      next_lo = {acc_lo[n-2:0], ~diff[n]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit, n+2 cycles start-to-done.
// Define MDU_SIGNED_EN to enable two's-complement MULT/DIV; otherwise they run as MULTU/DIVU.
//
// state | meaning
// IDLE  | accept start or mthi/mtlo writes
// CALC  | n radix-2 iterations on operand magnitudes
// FIXUP | sign correction / divide-by-zero override, commit HI/LO
// DONE  | done pulse visible, return to IDLE
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int n = MDU_N
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] srcA,
  input  logic [n-1:0] srcB,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo,
  output logic         div_by_zero
);

  localparam int ITERS = n * MDU_ITERS_PER_BIT;
  localparam int CW    = $clog2(ITERS + 1);

  mdu_state_e   state;
  logic [CW-1:0] cnt;
  logic [n-1:0] acc_hi, acc_lo, operand_q, a_q;
  logic         div_q, neg_q, rem_neg_q, dbz_q;

  mdu_op_e      op_e;
  logic         op_div, signed_op, a_neg, b_neg;
  logic [n-1:0] a_mag, b_mag;
  logic [n-1:0] step_hi, step_lo;

  logic [2*n-1:0] prod_raw, prod_fix;
  logic [n-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign op_e   = mdu_op_e'(op);
  assign op_div = (op_e == OP_DIVU) || (op_e == OP_DIV);

`ifdef MDU_SIGNED_EN
  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
`else
  assign signed_op = 1'b0;
`endif

  assign a_neg = signed_op & srcA[n-1];
  assign b_neg = signed_op & srcB[n-1];
  assign a_mag = a_neg ? -srcA : srcA;
  assign b_mag = b_neg ? -srcB : srcB;

  mdu_step #(.n(n)) u_step (
    .div_mode (div_q),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (operand_q),
    .next_hi  (step_hi),
    .next_lo  (step_lo)
  );

  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
    fix_hi   = prod_fix[2*n-1:n];
    fix_lo   = prod_fix[n-1:0];
    if (div_q) begin
      fix_hi = dbz_q ? a_q : rem_fix;
      fix_lo = dbz_q ? {n{1'b1}} : quo_fix;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      operand_q   <= '0;
      a_q         <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Multiply keeps the multiplier in acc_lo; divide shifts the dividend out of it.
            acc_hi    <= '0;
            acc_lo    <= op_div ? a_mag : b_mag;
            operand_q <= op_div ? b_mag : a_mag;
            a_q       <= srcA;
            div_q     <= op_div;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dbz_q     <= op_div && (srcB == '0);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ST_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= dbz_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          div_by_zero <= 1'b0;
          cnt         <= '0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops against an arithmetic model.
module tb_mult_div_unit;

  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic          CLK = 1'b0;
  logic          rst, start, hi_we, lo_we, busy, done, div_by_zero;
  logic [1:0]    op;
  logic [N-1:0]  srcA, srcB, wdata, hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mult_div_unit #(.n(N)) dut (
    .CLK(CLK), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial forever #5 CLK = ~CLK;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic exp_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    logic        sgn;
    longint      sa, sb, q, r;
    logic [63:0] p;
`ifdef MDU_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.dbz = 1'b0;
    if (!o[1]) begin
      p = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = 64'(q);
      e.lo = p[31:0];
      p = 64'(r);
      e.hi = p[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, input int rst_at, input logic we_start);
    int          cyc;
    int          done_cyc;
    logic [31:0] hi_before, lo_before;
    cyc = 0;
    done_cyc = 0;
    @(negedge CLK);
    hi_before = hi;
    lo_before = lo;
    op = o; srcA = a; srcB = b; start = 1'b1;
    hi_we = we_start; lo_we = we_start; wdata = 32'hDEAD_BEEF;
    if (rst_at < 0) exp_q.push_back(model(o, a, b));
    while (cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (done && done_cyc == 0) done_cyc = cyc;
      if (cyc == 1) check("busy_after_start", 64'(busy), 64'(1));
      if (cyc == 7) begin
        check("hi_write_while_busy", 64'(hi), 64'(hi_before));
        check("lo_write_while_busy", 64'(lo), 64'(lo_before));
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check("busy_after_rst", 64'(busy), 64'(0));
        check("hi_after_rst", 64'(hi), 64'(0));
        check("lo_after_rst", 64'(lo), 64'(0));
        rst = 1'b0;
      end
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      start = (cyc == restart_at);
      hi_we = (cyc == 5);
      lo_we = (cyc == 5);
      wdata = $urandom;
      srcA  = $urandom;
      srcB  = $urandom;
      if (done_cyc != 0 && rst_at < 0) break;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (rst_at < 0) begin
      check("latency", 64'(done_cyc), 64'(LAT));
      @(negedge CLK);
      check("done_single_cycle", 64'(done), 64'(0));
      check("busy_after_done", 64'(busy), 64'(0));
    end else begin
      check("no_done_after_rst", 64'(done_cyc), 64'(0));
    end
  endtask

  initial begin
    logic [31:0] ext [4];
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    ext[0] = 32'h8000_0000; ext[1] = 32'hFFFF_FFFF; ext[2] = 32'h0; ext[3] = 32'h1;
    rst = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd3, -1, -1, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
    run_op(2'b10, 32'd100, 32'd0, -1, -1, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 10, -1, 1'b0);

    @(negedge CLK);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge CLK);
    hi_we = 1'b0;
    check("mthi", 64'(hi), 64'(32'h1234_5678));
    lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge CLK);
    lo_we = 1'b0;
    check("mtlo", 64'(lo), 64'(32'h9ABC_DEF0));
    check("mthi_kept", 64'(hi), 64'(32'h1234_5678));

    run_op(2'b00, 32'd5, 32'd9, -1, -1, 1'b1);
    run_op(2'b00, $urandom, $urandom, -1, 15, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 1000));
        2: ra = ext[$urandom_range(0, 3)];
        default: ra = -32'($urandom_range(1, 1000));
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = ext[$urandom_range(0, 3)];
        2: rb = 32'($urandom_range(1, 50));
        3: rb = -32'($urandom_range(1, 50));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, (i % 5 == 0) ? 20 : -1, -1, 1'(i % 7 == 0));
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
